// File: rtl/mult_seq_ctrl.sv
// Sequential EX-stage multiplier: four half-width partial products accumulated
// over four cycles, sign-corrected, then written to HI/LO.

module mult_array #(
  parameter int WIDTH_H = 16
) (
  input  logic [WIDTH_H-1:0]   x_i,
  input  logic [WIDTH_H-1:0]   y_i,
  output logic [2*WIDTH_H-1:0] p_o
);
  assign p_o = {{WIDTH_H{1'b0}}, x_i} * {{WIDTH_H{1'b0}}, y_i};
endmodule

module mult_seq_ctrl #(
  parameter int WIDTH_D = 32,
  parameter int WIDTH_H = WIDTH_D / 2,
  parameter int WIDTH_P = 2 * WIDTH_D
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_op,
  input  logic               flush,
  input  logic [WIDTH_D-1:0] a,
  input  logic [WIDTH_D-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_D-1:0] hi,
  output logic [WIDTH_D-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, FIX, DONE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH_D-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH_D-1:0]   mag_b_q, mag_b_d;
  logic                 neg_q, neg_d;
  logic [WIDTH_P-1:0]   acc_q, acc_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [WIDTH_D-1:0]   hi_q, hi_d;
  logic [WIDTH_D-1:0]   lo_q, lo_d;

  logic [WIDTH_D-1:0]   abs_a, abs_b;
  logic [WIDTH_H-1:0]   op_x, op_y;
  logic [2*WIDTH_H-1:0] pp;
  logic [WIDTH_P-1:0]   pp_ext, pp_shift, fixed;

  // The most-negative operand negates to itself, which is the correct unsigned magnitude.
  assign abs_a = (signed_op && a[WIDTH_D-1]) ? -a : a;
  assign abs_b = (signed_op && b[WIDTH_D-1]) ? -b : b;

  assign op_x = cnt_q[1] ? mag_a_q[WIDTH_D-1:WIDTH_H] : mag_a_q[WIDTH_H-1:0];
  assign op_y = cnt_q[0] ? mag_b_q[WIDTH_D-1:WIDTH_H] : mag_b_q[WIDTH_H-1:0];

  mult_array #(.WIDTH_H(WIDTH_H)) u_mult_array (
    .x_i (op_x),
    .y_i (op_y),
    .p_o (pp)
  );

  assign pp_ext = {{WIDTH_D{1'b0}}, pp};
  assign fixed  = neg_q ? -acc_q : acc_q;

  always_comb begin
    pp_shift = pp_ext;
    case (cnt_q)
      2'd0:    pp_shift = pp_ext;
      2'd1,
      2'd2:    pp_shift = pp_ext << WIDTH_H;
      default: pp_shift = pp_ext << WIDTH_D;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Flush wins everywhere, including over a start arriving in IDLE.
  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          mag_a_d = abs_a;
          mag_b_d = abs_b;
          neg_d   = signed_op & (a[WIDTH_D-1] ^ b[WIDTH_D-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_q + pp_shift;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = FIX;
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          {hi_d, lo_d} = fixed;
          state_d      = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: a 32-bit instance for the directed cases
// and a 4-bit instance for an exhaustive signed/unsigned sweep.

module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, signedOp, flush;
  logic [31:0] a, b, hi, lo;
  logic        busy, done;

  logic        start4, signed4, flush4;
  logic [3:0]  a4, b4, hi4, lo4;
  logic        busy4, done4;

  int nTotal = 0;
  int nBad   = 0;

  logic [63:0] expQ[$];
  logic [7:0]  expQ4[$];

  always #5 clk = ~clk;

  mult_seq_ctrl #(.WIDTH_D(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signedOp), .flush(flush),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mult_seq_ctrl #(.WIDTH_D(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_op(signed4), .flush(flush4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
  );

  // Pulses start for one edge; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb_, input logic ts);
    a = ta; b = tb_; signedOp = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(output int lat, output bit timedOut);
    lat = 0; timedOut = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = i; timedOut = 1'b0; break; end
    end
  endtask

  task automatic applyStimulus4(input logic [3:0] ta, input logic [3:0] tb_, input logic ts);
    a4 = ta; b4 = tb_; signed4 = ts; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic waitDone4(output bit timedOut);
    timedOut = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done4 === 1'b1) begin timedOut = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; signedOp = 1'b0; flush = 1'b0; a = '0; b = '0;
    start4 = 1'b0; signed4 = 1'b0; flush4 = 1'b0; a4 = '0; b4 = '0;
    #2;
    nTotal++; if (busy !== 1'b0) begin nBad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    nTotal++; if (done !== 1'b0) begin nBad++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    nTotal++; if (hi !== 32'h0) begin nBad++; $display("[TB] FAIL reset_hi: got %h want 0", hi); end
    nTotal++; if (lo !== 32'h0) begin nBad++; $display("[TB] FAIL reset_lo: got %h want 0", lo); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_latency();
    logic [63:0] exp;
    expQ.push_back(64'hFFFFFFFE_00000001);
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    nTotal++; if (busy !== 1'b1) begin nBad++; $display("[TB] FAIL lat_busy_k: got %b want 1", busy); end
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      nTotal++;
      if (done !== 1'(i == 5)) begin
        nBad++; $display("[TB] FAIL lat_done_k+%0d: got %b want %b", i, done, (i == 5));
      end
      if (i == 5) begin
        exp = expQ.pop_front();
        nTotal++;
        if ({hi, lo} !== exp) begin nBad++; $display("[TB] FAIL lat_value: got %h want %h", {hi, lo}, exp); end
      end
    end
    nTotal++; if (busy !== 1'b0) begin nBad++; $display("[TB] FAIL lat_busy_k+6: got %b want 0", busy); end
  endtask

  task automatic test_signed_cases();
    logic [31:0] ca[5], cb[5];
    logic        cs[5];
    logic [63:0] ce[5];
    logic [63:0] exp;
    int          lat;
    bit          to;
    ca = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    cb = '{32'h00000005, 32'h00000005, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    cs = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    ce = '{64'hFFFFFFFF_FFFFFFF1, 64'h00000004_FFFFFFF1, 64'h40000000_00000000,
           64'h00000000_00000001, 64'h00000000_00000000};
    for (int i = 0; i < 5; i++) begin
      expQ.push_back(ce[i]);
      applyStimulus(ca[i], cb[i], cs[i]);
      waitDone(lat, to);
      exp = expQ.pop_front();
      nTotal++;
      if (to || {hi, lo} !== exp) begin
        nBad++; $display("[TB] FAIL signed_case%0d: got %h (timeout=%0d) want %h", i, {hi, lo}, to, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    int          lat;
    bit          to;
    expQ.push_back(64'd63);
    applyStimulus(32'd7, 32'd9, 1'b0);
    @(posedge clk); #1;
    a = 32'd100; b = 32'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(lat, to);
    exp = expQ.pop_front();
    nTotal++;
    if (to || {hi, lo} !== exp) begin
      nBad++; $display("[TB] FAIL ignore_start: got %h (timeout=%0d) want %h", {hi, lo}, to, exp);
    end
    @(posedge clk); #1;
    nTotal++; if (busy !== 1'b0) begin nBad++; $display("[TB] FAIL b2b_idle: got busy %b want 0", busy); end
    expQ.push_back(64'd12);
    applyStimulus(32'd3, 32'd4, 1'b0);
    waitDone(lat, to);
    exp = expQ.pop_front();
    nTotal++;
    if (to || lat != 5 || {hi, lo} !== exp) begin
      nBad++; $display("[TB] FAIL b2b_second: got %h lat %0d want %h lat 5", {hi, lo}, lat, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    logic [63:0] exp;
    int          lat;
    bit          to;
    bit          sawDone;
    expQ.push_back(64'h00000012_00000034);
    applyStimulus(32'd20, 32'hE6666669, 1'b0);
    waitDone(lat, to);
    exp = expQ.pop_front();
    nTotal++;
    if (to || {hi, lo} !== exp) begin
      nBad++; $display("[TB] FAIL flush_prior: got %h want %h", {hi, lo}, exp);
    end
    @(posedge clk); #1;
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    nTotal++; if (busy !== 1'b0) begin nBad++; $display("[TB] FAIL flush_busy: got %b want 0", busy); end
    nTotal++; if (hi !== 32'h12) begin nBad++; $display("[TB] FAIL flush_hi: got %h want 12", hi); end
    nTotal++; if (lo !== 32'h34) begin nBad++; $display("[TB] FAIL flush_lo: got %h want 34", lo); end
    sawDone = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (done !== 1'b0) sawDone = 1'b1;
      @(posedge clk); #1;
    end
    nTotal++; if (sawDone) begin nBad++; $display("[TB] FAIL flush_no_done: got done pulse want none"); end
    a = 32'd5; b = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    nTotal++; if (busy !== 1'b0) begin nBad++; $display("[TB] FAIL flush_over_start: got busy %b want 0", busy); end
    nTotal++; if ({hi, lo} !== 64'h00000012_00000034) begin
      nBad++; $display("[TB] FAIL flush_hold: got %h want 0000001200000034", {hi, lo});
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    nTotal++; if (busy !== 1'b1) begin nBad++; $display("[TB] FAIL arst_pre_busy: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    nTotal++; if (busy !== 1'b0) begin nBad++; $display("[TB] FAIL arst_busy: got %b want 0", busy); end
    nTotal++; if (done !== 1'b0) begin nBad++; $display("[TB] FAIL arst_done: got %b want 0", done); end
    nTotal++; if (hi !== 32'h0) begin nBad++; $display("[TB] FAIL arst_hi: got %h want 0", hi); end
    nTotal++; if (lo !== 32'h0) begin nBad++; $display("[TB] FAIL arst_lo: got %h want 0", lo); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sweep4();
    logic signed [7:0] sx, sy;
    logic [7:0]        exp;
    bit                to;
    for (int s = 0; s < 2; s++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          if (s == 1) begin
            sx = $signed(4'(ia));
            sy = $signed(4'(ib));
          end else begin
            sx = 8'(ia);
            sy = 8'(ib);
          end
          expQ4.push_back(8'(sx * sy));
          applyStimulus4(4'(ia), 4'(ib), 1'(s));
          waitDone4(to);
          exp = expQ4.pop_front();
          nTotal++;
          if (to || {hi4, lo4} !== exp) begin
            nBad++;
            $display("[TB] FAIL sweep s=%0d a=%0d b=%0d: got %h (timeout=%0d) want %h",
                     s, ia, ib, {hi4, lo4}, to, exp);
          end
          @(posedge clk); #1;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_latency();
    test_signed_cases();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_sweep4();
    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
